// File: rtl/branch_predictor.sv
// Branch predictor: direct-mapped BTB/BHT with 2-bit saturating counters,
// plus execute-stage branch resolution and redirect generation.
//
// Ports:
//   clk, reset        rising-edge clock, asynchronous active-high reset
//   IF_PC             fetch PC to look up
//   Pred_Taken/PC     fetch-stage prediction (combinational)
//   Ex_*              resolving instruction in EX, with the prediction it carried
//   Imm, Branch, JalrSel, Halt, AluResult   EX decode/ALU info
//   PC_Imm, PC_Four   EX arithmetic (Ex_PC+Imm, Ex_PC+4)
//   BrPC, PcSel       redirect target and flush request
//   Br_Cnt            count of resolved branches/jumps
//   Mispred_Cnt       count of redirects other than halts
module branch_predictor #(
    parameter int PC_W    = 9,
    parameter int ENTRIES = 16,
    localparam int IDX_W  = $clog2(ENTRIES),
    localparam int TAG_W  = PC_W - IDX_W - 2
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [PC_W-1:0] IF_PC,
    output logic            Pred_Taken,
    output logic [31:0]     Pred_PC,
    input  logic            Ex_Valid,
    input  logic [PC_W-1:0] Ex_PC,
    input  logic [31:0]     Imm,
    input  logic            Branch,
    input  logic            JalrSel,
    input  logic            Halt,
    input  logic [31:0]     AluResult,
    input  logic            Ex_PredTaken,
    input  logic [31:0]     Ex_PredTarget,
    output logic [31:0]     PC_Imm,
    output logic [31:0]     PC_Four,
    output logic [31:0]     BrPC,
    output logic            PcSel,
    output logic [31:0]     Br_Cnt,
    output logic [31:0]     Mispred_Cnt
);

    typedef struct packed {
        logic             valid;
        logic [TAG_W-1:0] tag;
        logic [31:0]      target;
        logic [1:0]       ctr;
    } entry_t;

    entry_t btb [ENTRIES];

    // ---------------- fetch-side lookup ----------------
    logic [IDX_W-1:0] if_idx;
    logic [TAG_W-1:0] if_tag;
    logic [31:0]      if_pc32;
    logic             if_hit;

    assign if_idx  = IF_PC[IDX_W+1:2];
    assign if_tag  = IF_PC[PC_W-1:IDX_W+2];
    assign if_pc32 = 32'(IF_PC);
    assign if_hit  = btb[if_idx].valid && (btb[if_idx].tag == if_tag);

    assign Pred_Taken = if_hit && btb[if_idx].ctr[1];
    assign Pred_PC    = Pred_Taken ? btb[if_idx].target : if_pc32 + 32'd4;

    // ---------------- execute-side resolution ----------------
    logic [IDX_W-1:0] ex_idx;
    logic [TAG_W-1:0] ex_tag;
    logic [31:0]      ex_pc32;
    logic             ex_hit;
    logic             act_taken;
    logic [31:0]      act_target;
    logic             upd_en;

    assign ex_idx  = Ex_PC[IDX_W+1:2];
    assign ex_tag  = Ex_PC[PC_W-1:IDX_W+2];
    assign ex_pc32 = 32'(Ex_PC);
    assign ex_hit  = btb[ex_idx].valid && (btb[ex_idx].tag == ex_tag);

    assign PC_Imm  = ex_pc32 + Imm;
    assign PC_Four = ex_pc32 + 32'd4;

    // jalr overrides Branch: it is always taken to the ALU-computed target
    assign act_taken  = JalrSel || (Branch && AluResult[0]);
    assign act_target = JalrSel ? AluResult : PC_Imm;

    assign PcSel = Ex_Valid && (Halt || (act_taken != Ex_PredTaken) ||
                                (act_taken && (act_target != Ex_PredTarget)));

    // Halt parks fetch on the halting instruction itself
    always_comb begin
        BrPC = PC_Four;
        if (Halt)           BrPC = ex_pc32;
        else if (act_taken) BrPC = act_target;
    end

    assign upd_en = Ex_Valid && (Branch || JalrSel) && !Halt;

    // ---------------- table update ----------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < ENTRIES; i++) begin
                btb[i].valid  <= 1'b0;
                btb[i].tag    <= '0;
                btb[i].target <= 32'd0;
                btb[i].ctr    <= 2'b01;
            end
        end else if (upd_en) begin
            if (act_taken) begin
                btb[ex_idx].valid  <= 1'b1;
                btb[ex_idx].tag    <= ex_tag;
                btb[ex_idx].target <= act_target;
                // a fresh allocation starts weakly taken
                if (!ex_hit)
                    btb[ex_idx].ctr <= 2'b10;
                else if (btb[ex_idx].ctr != 2'b11)
                    btb[ex_idx].ctr <= btb[ex_idx].ctr + 2'b01;
            end else if (ex_hit && (btb[ex_idx].ctr != 2'b00)) begin
                btb[ex_idx].ctr <= btb[ex_idx].ctr - 2'b01;
            end
        end
    end

    // ---------------- statistics ----------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            Br_Cnt      <= 32'd0;
            Mispred_Cnt <= 32'd0;
        end else begin
            if (upd_en && (Br_Cnt != 32'hFFFF_FFFF))
                Br_Cnt <= Br_Cnt + 32'd1;
            if (PcSel && !Halt && (Mispred_Cnt != 32'hFFFF_FFFF))
                Mispred_Cnt <= Mispred_Cnt + 32'd1;
        end
    end

endmodule

// File: tb/tb_branch_predictor.sv
// Directed bench for branch_predictor (PC_W=9, ENTRIES=16).
// Vectors are applied on the falling edge and checked 1ns later; the
// following rising edge commits any update the vector requested.
module tb_branch_predictor;

    logic        clk = 1'b0;
    logic        reset;
    logic [8:0]  IF_PC;
    logic        Pred_Taken;
    logic [31:0] Pred_PC;
    logic        Ex_Valid;
    logic [8:0]  Ex_PC;
    logic [31:0] Imm;
    logic        Branch, JalrSel, Halt;
    logic [31:0] AluResult;
    logic        Ex_PredTaken;
    logic [31:0] Ex_PredTarget;
    logic [31:0] PC_Imm, PC_Four, BrPC;
    logic        PcSel;
    logic [31:0] Br_Cnt, Mispred_Cnt;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    branch_predictor #(.PC_W(9), .ENTRIES(16)) dut (
        .clk(clk), .reset(reset), .IF_PC(IF_PC),
        .Pred_Taken(Pred_Taken), .Pred_PC(Pred_PC),
        .Ex_Valid(Ex_Valid), .Ex_PC(Ex_PC), .Imm(Imm),
        .Branch(Branch), .JalrSel(JalrSel), .Halt(Halt),
        .AluResult(AluResult), .Ex_PredTaken(Ex_PredTaken),
        .Ex_PredTarget(Ex_PredTarget), .PC_Imm(PC_Imm), .PC_Four(PC_Four),
        .BrPC(BrPC), .PcSel(PcSel), .Br_Cnt(Br_Cnt), .Mispred_Cnt(Mispred_Cnt)
    );

    typedef struct {
        logic [8:0]  if_pc;
        logic        ev;
        logic [8:0]  ex_pc;
        logic [31:0] imm;
        logic        br, jr, hl;
        logic [31:0] alu;
        logic        pt;
        logic [31:0] ptgt;
        logic        e_pt;
        logic [31:0] e_ppc;
        logic        e_sel;
        logic        chk_brpc;
        logic [31:0] e_brpc, e_imm, e_four, e_bc, e_mc;
    } vec_t;

    vec_t vt [16];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    task automatic idle_ex();
        Ex_Valid = 0; Ex_PC = '0; Imm = '0; Branch = 0; JalrSel = 0; Halt = 0;
        AluResult = '0; Ex_PredTaken = 0; Ex_PredTarget = '0;
    endtask

    // One resolved conditional branch at pc (target pc+0x20), then EX idles.
    task automatic step_branch(input logic [8:0] pc, input logic taken);
        @(negedge clk);
        Ex_Valid = 1; Ex_PC = pc; Imm = 32'h20; Branch = 1; JalrSel = 0; Halt = 0;
        AluResult = {31'd0, taken}; Ex_PredTaken = 0; Ex_PredTarget = '0;
        @(negedge clk);
        idle_ex();
        #1;
    endtask

    initial begin
        //          if_pc   ev ex_pc   imm            br jr hl alu        pt ptgt      e_pt e_ppc      sel chk e_brpc     e_imm      e_four    bc mc
        vt[0]  = '{9'h040, 0, 9'h000, 32'h0,        0, 0, 0, 32'h0,     0, 32'h0,    0, 32'h044,  0, 1, 32'h004, 32'h000,  32'h004, 0, 0};
        vt[1]  = '{9'h040, 1, 9'h040, 32'h20,       1, 0, 0, 32'h1,     0, 32'h0,    0, 32'h044,  1, 1, 32'h060, 32'h060,  32'h044, 0, 0};
        vt[2]  = '{9'h040, 1, 9'h040, 32'h20,       1, 0, 0, 32'h1,     1, 32'h060,  1, 32'h060,  0, 1, 32'h060, 32'h060,  32'h044, 1, 1};
        vt[3]  = '{9'h080, 1, 9'h040, 32'h20,       1, 0, 0, 32'h0,     1, 32'h060,  0, 32'h084,  1, 1, 32'h044, 32'h060,  32'h044, 2, 1};
        vt[4]  = '{9'h040, 1, 9'h040, 32'h20,       1, 0, 0, 32'h0,     1, 32'h060,  1, 32'h060,  1, 1, 32'h044, 32'h060,  32'h044, 3, 2};
        vt[5]  = '{9'h040, 0, 9'h040, 32'h20,       1, 0, 0, 32'h1,     0, 32'h0,    0, 32'h044,  0, 0, 32'h000, 32'h060,  32'h044, 4, 3};
        vt[6]  = '{9'h010, 1, 9'h010, 32'h8,        1, 1, 0, 32'h1A4,   0, 32'h0,    0, 32'h014,  1, 1, 32'h1A4, 32'h018,  32'h014, 4, 3};
        vt[7]  = '{9'h010, 0, 9'h010, 32'h8,        0, 0, 0, 32'h0,     0, 32'h0,    1, 32'h1A4,  0, 1, 32'h014, 32'h018,  32'h014, 5, 4};
        vt[8]  = '{9'h010, 1, 9'h010, 32'h8,        0, 1, 0, 32'h1A4,   1, 32'h1A4,  1, 32'h1A4,  0, 1, 32'h1A4, 32'h018,  32'h014, 5, 4};
        vt[9]  = '{9'h010, 1, 9'h010, 32'h8,        0, 1, 0, 32'h0C8,   1, 32'h1A4,  1, 32'h1A4,  1, 1, 32'h0C8, 32'h018,  32'h014, 6, 4};
        vt[10] = '{9'h010, 0, 9'h010, 32'h8,        0, 0, 0, 32'h0,     0, 32'h0,    1, 32'h0C8,  0, 1, 32'h014, 32'h018,  32'h014, 7, 5};
        vt[11] = '{9'h100, 1, 9'h100, 32'h20,       1, 0, 1, 32'h1,     0, 32'h0,    0, 32'h104,  1, 1, 32'h100, 32'h120,  32'h104, 7, 5};
        vt[12] = '{9'h100, 0, 9'h100, 32'h20,       0, 0, 0, 32'h0,     0, 32'h0,    0, 32'h104,  0, 1, 32'h104, 32'h120,  32'h104, 7, 5};
        vt[13] = '{9'h040, 1, 9'h0C0, 32'h20,       1, 0, 0, 32'h0,     0, 32'h0,    0, 32'h044,  0, 1, 32'h0C4, 32'h0E0,  32'h0C4, 7, 5};
        vt[14] = '{9'h0C0, 0, 9'h0C0, 32'h20,       0, 0, 0, 32'h0,     0, 32'h0,    0, 32'h0C4,  0, 1, 32'h0C4, 32'h0E0,  32'h0C4, 8, 5};
        vt[15] = '{9'h040, 0, 9'h040, 32'hFFFFFFF0, 0, 0, 0, 32'h0,     0, 32'h0,    0, 32'h044,  0, 1, 32'h044, 32'h030,  32'h044, 8, 5};

        reset = 1; IF_PC = '0; idle_ex();
        @(negedge clk); @(negedge clk);
        reset = 0;

        foreach (vt[i]) begin
            @(negedge clk);
            IF_PC = vt[i].if_pc; Ex_Valid = vt[i].ev; Ex_PC = vt[i].ex_pc; Imm = vt[i].imm;
            Branch = vt[i].br; JalrSel = vt[i].jr; Halt = vt[i].hl; AluResult = vt[i].alu;
            Ex_PredTaken = vt[i].pt; Ex_PredTarget = vt[i].ptgt;
            #1;
            check($sformatf("v%0d Pred_Taken", i), 32'(Pred_Taken), 32'(vt[i].e_pt));
            check($sformatf("v%0d Pred_PC", i), Pred_PC, vt[i].e_ppc);
            check($sformatf("v%0d PcSel", i), 32'(PcSel), 32'(vt[i].e_sel));
            if (vt[i].chk_brpc) check($sformatf("v%0d BrPC", i), BrPC, vt[i].e_brpc);
            check($sformatf("v%0d PC_Imm", i), PC_Imm, vt[i].e_imm);
            check($sformatf("v%0d PC_Four", i), PC_Four, vt[i].e_four);
            check($sformatf("v%0d Br_Cnt", i), Br_Cnt, vt[i].e_bc);
            check($sformatf("v%0d Mispred_Cnt", i), Mispred_Cnt, vt[i].e_mc);
        end

        // Asynchronous reset landing on a cycle with a pending taken update:
        // the update must be dropped and the 0x010 entry (predicting taken) cleared.
        @(negedge clk);
        idle_ex();
        IF_PC = 9'h010; Ex_Valid = 1; Ex_PC = 9'h040; Imm = 32'h20; Branch = 1; AluResult = 32'h1;
        #1;
        reset = 1;
        #1;
        check("rst Pred_Taken", 32'(Pred_Taken), 32'd0);
        check("rst Pred_PC", Pred_PC, 32'h014);
        check("rst Br_Cnt", Br_Cnt, 32'd0);
        check("rst Mispred_Cnt", Mispred_Cnt, 32'd0);
        @(negedge clk);
        reset = 0; idle_ex(); IF_PC = 9'h040;
        #1;
        check("post-rst 0x040 Pred_Taken", 32'(Pred_Taken), 32'd0);
        check("post-rst 0x040 Pred_PC", Pred_PC, 32'h044);

        // Counter saturation at 00: T(10) N(01) N(00) N(00) T(01) T(10)
        IF_PC = 9'h040;
        step_branch(9'h040, 1); check("sat T1 Pred_Taken", 32'(Pred_Taken), 32'd1);
        check("sat T1 Pred_PC", Pred_PC, 32'h060);
        step_branch(9'h040, 0); check("sat N1 Pred_Taken", 32'(Pred_Taken), 32'd0);
        step_branch(9'h040, 0);
        step_branch(9'h040, 0); check("sat N3 Pred_Taken", 32'(Pred_Taken), 32'd0);
        step_branch(9'h040, 1); check("sat T2 Pred_Taken", 32'(Pred_Taken), 32'd0);
        step_branch(9'h040, 1); check("sat T3 Pred_Taken", 32'(Pred_Taken), 32'd1);
        check("sat Br_Cnt", Br_Cnt, 32'd6);
        check("sat Mispred_Cnt", Mispred_Cnt, 32'd3);

        // Final reset pulse clears table and counters
        @(negedge clk);
        reset = 1;
        @(negedge clk);
        reset = 0;
        #1;
        check("final Pred_Taken", 32'(Pred_Taken), 32'd0);
        check("final Pred_PC", Pred_PC, 32'h044);
        check("final Br_Cnt", Br_Cnt, 32'd0);
        check("final Mispred_Cnt", Mispred_Cnt, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/branch_predictor.md
BRANCH_PREDICTOR -- requirements
Module: branch_predictor

Interface
REQ-001 Parameters SHALL be: PC_W, default 9, PC width; ENTRIES, default 16, BTB/BHT depth, power of 2, >=2; IDX_W = log2(ENTRIES); PC_W >= IDX_W+3.
REQ-002 Ports SHALL be, clock and reset first:
- clk  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-high.
- IF_PC  in  PC_W  fetch-stage PC.
- Pred_Taken  out  1  fetch prediction.
- Pred_PC  out  32  predicted next fetch PC.
- Ex_Valid  in  1  EX slot holds a real instruction.
- Ex_PC  in  PC_W  PC of the EX instruction.
- Imm  in  32  branch/jal immediate.
- Branch  in  1  conditional branch or jal.
- JalrSel  in  1  jalr.
- Halt  in  1  halt.
- AluResult  in  32  bit0 = condition; jalr target.
- Ex_PredTaken  in  1  prediction carried down with the instruction.
- Ex_PredTarget  in  32  predicted target carried down.
- PC_Imm  out  32  Ex_PC+Imm.
- PC_Four  out  32  Ex_PC+4.
- BrPC  out  32  redirect PC.
- PcSel  out  1  redirect/flush request.
- Br_Cnt  out  32  resolved control-transfer count.
- Mispred_Cnt  out  32  redirect count, excluding halts.

Function
REQ-003 Storage SHALL be ENTRIES entries, each holding: valid bit, tag = PC[PC_W-1:IDX_W+2], 32-bit target, 2-bit saturating counter. Index = PC[IDX_W+1:2].
REQ-004 Lookup SHALL be combinational from registered state.
- Hit = valid && tag match at index of IF_PC.
- Pred_Taken = hit && ctr[1].
- Pred_PC = Pred_Taken ? target : zero-extended IF_PC + 4.
REQ-005 Arithmetic SHALL zero-extend PC to 32 bits. PC_Imm and PC_Four wrap modulo 2^32.
REQ-006 When Ex_Valid=1, the actual outcome SHALL be:
- ActTaken = JalrSel || (Branch && AluResult[0]).
- ActTarget = JalrSel ? AluResult : PC_Imm.
- If JalrSel=1, Branch is ignored.
REQ-007 PcSel SHALL be combinational and equal Ex_Valid && (Halt || ActTaken != Ex_PredTaken || (ActTaken && ActTarget != Ex_PredTarget)).
REQ-008 BrPC SHALL be:
- Halt: Ex_PC, zero-extended. Halt has priority over JalrSel and Branch.
- else ActTaken: ActTarget.
- else: PC_Four.
- When PcSel=0, BrPC is don't-care but SHALL still follow this rule.
REQ-009 An update SHALL occur on the rising edge when Ex_Valid && (Branch || JalrSel) && !Halt.
REQ-010 Update on taken, hit: ctr saturating increment (max 11); target := ActTarget.
REQ-011 Update on taken, miss: allocate/overwrite entry; valid := 1, tag, target := ActTarget, ctr := 10.
REQ-012 Update on not taken, hit: ctr saturating decrement (min 00). Not taken, miss: no change.
REQ-013 Same-cycle lookup and update at one index SHALL return pre-update contents. The new value is visible from the next cycle.
REQ-014 On each update event, Br_Cnt SHALL increment. Mispred_Cnt SHALL increment when PcSel=1 and Halt=0. Both saturate at 0xFFFFFFFF.
REQ-015 Ex_Valid=0 SHALL force PcSel=0 and block table and counter updates.
REQ-016 Halt SHALL cause no table or counter change.

Reset
REQ-017 While reset=1, asynchronously:
- all valid := 0, ctr := 01, target := 0, tag := 0.
- Br_Cnt := 0, Mispred_Cnt := 0.
REQ-018 During reset, combinational outputs SHALL reflect the cleared state: Pred_Taken=0, Pred_PC=IF_PC+4.
REQ-019 Reset asserted mid-operation SHALL discard any update pending on that edge.

Verification (PC_W=9, ENTRIES=16)
REQ-020 After reset, IF_PC=0x040 -> Pred_Taken=0, Pred_PC=0x044, counters 0.
REQ-021 Ex_PC=0x040, Imm=0x20, Branch=1, AluResult=1, Ex_PredTaken=0 -> PcSel=1, BrPC=0x060, Mispred_Cnt=1. Next cycle IF_PC=0x040 -> Pred_Taken=1, Pred_PC=0x060.
REQ-022 Continue the REQ-021 sequence:
- Same branch, taken again, Ex_PredTaken=1, Ex_PredTarget=0x060 -> PcSel=0, ctr=11.
- Then not-taken with Ex_PredTaken=1 -> PcSel=1, BrPC=0x044.
- Second not-taken -> ctr=01, Pred_Taken=0.
REQ-023 After REQ-021, IF_PC=0x080 (same index, different tag) -> Pred_Taken=0, Pred_PC=0x084.
REQ-024 JalrSel=1, AluResult=0x1A4, Ex_PC=0x010, Ex_PredTaken=0 -> PcSel=1, BrPC=0x1A4. Next cycle IF_PC=0x010 -> Pred_PC=0x1A4.
REQ-025 Halt=1, Ex_PC=0x100 -> PcSel=1, BrPC=0x100, Br_Cnt and Mispred_Cnt unchanged. A following reset pulse clears all entries and counters.
